// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write and read controllers.
// Gray conversion, depth calculation and synchroniser-depth limits.
package fifo_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int GRAY_MAX_W      = 32;

   function automatic int depth_of(input int abits);
      return 1 << abits;
   endfunction

   // Callers zero-extend narrower pointers to GRAY_MAX_W and size-cast the result.
   // Leading zeros convert to leading zeros, so one function serves every pointer width.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency STAGES cycles of clk; no flow control, samples every cycle.
module fifo_gray_sync #(
   parameter int W      = 11,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: write pointer, full/almost-full, level, overflow.
// Status reflects a write one edge later; reads appear after SYNC_STAGES more edges.
// Writes while full are dropped and latched in the sticky overflow flag.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int ABITS       = 10,
   parameter int SYNC_STAGES = 2,
   parameter int AF_HYST     = 0
) (
   input  logic             wrclk,
   input  logic             rst_n,
   input  logic             wr_en,
   output logic [ABITS-1:0] wr_addr,
   output logic             wr_we,
   output logic [ABITS:0]   wr_gray_ptr,
   input  logic [ABITS:0]   rd_gray_ptr,
   input  logic [ABITS:0]   afull_thr,
   output logic             full,
   output logic             almost_full,
   output logic [ABITS:0]   wr_level,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int            PW     = ABITS + 1;
   localparam int            DEPTH  = depth_of(ABITS);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] HYST_P  = PW'(AF_HYST);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("fifo_wr_ctrl: SYNC_STAGES out of range");
   end
   if (AF_HYST < 0 || AF_HYST > DEPTH - 1 || PW > GRAY_MAX_W) begin : g_bad_param
      $error("fifo_wr_ctrl: AF_HYST or ABITS out of range");
   end

   logic [PW-1:0] wr_bin;
   logic [PW-1:0] wr_bin_nxt;
   logic [PW-1:0] wr_gray_nxt;
   logic [PW-1:0] rd_gray_s;
   logic [PW-1:0] rd_bin_s;
   logic [PW-1:0] lvl_nxt;
   logic [PW-1:0] af_lo;

   fifo_gray_sync #(
      .W      (PW),
      .STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .clk   (wrclk),
      .rst_n (rst_n),
      .d     (rd_gray_ptr),
      .q     (rd_gray_s)
   );

   assign wr_we   = wr_en & ~full;
   assign wr_addr = wr_bin[ABITS-1:0];

   always_comb begin
      wr_bin_nxt  = wr_bin + PW'(wr_we);
      wr_gray_nxt = PW'(bin2gray(GRAY_MAX_W'(wr_bin_nxt)));
      rd_bin_s    = PW'(gray2bin(GRAY_MAX_W'(rd_gray_s)));
      // Modular difference stays correct across pointer wrap; MSB separates full from empty.
      lvl_nxt     = wr_bin_nxt - rd_bin_s;
      af_lo       = (afull_thr > HYST_P) ? (afull_thr - HYST_P) : '0;
   end

   always_ff @(posedge wrclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bin      <= '0;
         wr_gray_ptr <= '0;
         wr_level    <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         wr_bin      <= wr_bin_nxt;
         wr_gray_ptr <= wr_gray_nxt;
         wr_level    <= lvl_nxt;
         full        <= (lvl_nxt == DEPTH_P);
         if (lvl_nxt >= afull_thr) begin
            almost_full <= 1'b1;
         end else if (lvl_nxt < af_lo) begin
            almost_full <= 1'b0;
         end
         // A dropped write in the same cycle as a clear leaves the flag set.
         if (wr_en && full) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with ABITS=4, SYNC_STAGES=2, AF_HYST=3.
module tb_fifo_wr_ctrl;

   logic       wrclk;
   logic       rst_n;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic       wr_we;
   logic [4:0] wr_gray_ptr;
   logic [4:0] rd_gray_ptr;
   logic [4:0] afull_thr;
   logic       full;
   logic       almost_full;
   logic [4:0] wr_level;
   logic       overflow;
   logic       ovf_clr;

   int n_assert = 0;
   int n_fail   = 0;
   logic [4:0] prev_gray;

   fifo_wr_ctrl #(
      .ABITS       (4),
      .SYNC_STAGES (2),
      .AF_HYST     (3)
   ) dut (
      .wrclk       (wrclk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_we       (wr_we),
      .wr_gray_ptr (wr_gray_ptr),
      .rd_gray_ptr (rd_gray_ptr),
      .afull_thr   (afull_thr),
      .full        (full),
      .almost_full (almost_full),
      .wr_level    (wr_level),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   initial wrclk = 1'b0;
   always #5 wrclk = ~wrclk;

   function automatic logic [4:0] g(input int b);
      logic [4:0] x;
      x = 5'(b);
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge wrclk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " wr_addr"},     32'(wr_addr),     0);
      chk({tag, " wr_gray_ptr"}, 32'(wr_gray_ptr), 0);
      chk({tag, " wr_level"},    32'(wr_level),    0);
      chk({tag, " full"},        32'(full),        0);
      chk({tag, " almost_full"}, 32'(almost_full), 0);
      chk({tag, " overflow"},    32'(overflow),    0);
   endtask

   initial begin
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      ovf_clr     = 1'b0;
      rd_gray_ptr = '0;
      afull_thr   = 5'd12;
      #2;
      chk_all_zero("reset");
      #20;
      rst_n = 1'b1;
      tick();

      // Fill to full
      wr_en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         prev_gray = wr_gray_ptr;
         tick();
         chk("fill level",      32'(wr_level), 32'(i));
         chk("fill addr",       32'(wr_addr), 32'(i % 16));
         chk("fill gray",       32'(wr_gray_ptr), 32'(g(i)));
         chk("fill gray 1bit",  32'($countones(wr_gray_ptr ^ prev_gray)), 1);
         chk("fill full",       32'(full), (i == 16) ? 1 : 0);
         chk("fill afull",      32'(almost_full), (i >= 12) ? 1 : 0);
      end
      chk("wr_we when full", 32'(wr_we), 0);
      tick();
      chk("17th addr",     32'(wr_addr), 0);
      chk("17th level",    32'(wr_level), 16);
      chk("17th gray",     32'(wr_gray_ptr), 32'h18);
      chk("17th overflow", 32'(overflow), 1);

      // Overflow clear and set-wins
      wr_en = 1'b0; ovf_clr = 1'b1;
      tick();
      chk("ovf clr alone", 32'(overflow), 0);
      wr_en = 1'b1;
      tick();
      chk("ovf set wins", 32'(overflow), 1);
      wr_en = 1'b0;
      tick();
      chk("ovf clr again", 32'(overflow), 0);
      ovf_clr = 1'b0;

      // Read latency: two synchroniser edges before status moves
      rd_gray_ptr = g(1);
      tick();
      chk("rdlat M level",   32'(wr_level), 16);
      chk("rdlat M full",    32'(full), 1);
      tick();
      chk("rdlat M+1 level", 32'(wr_level), 16);
      chk("rdlat M+1 full",  32'(full), 1);
      tick();
      chk("rdlat M+2 level", 32'(wr_level), 15);
      chk("rdlat M+2 full",  32'(full), 0);

      // Almost-full hysteresis, thr=12, hyst=3
      rd_gray_ptr = g(6);
      tick(); tick(); tick();
      chk("hyst lvl10",   32'(wr_level), 10);
      chk("hyst afull10", 32'(almost_full), 1);
      rd_gray_ptr = g(7);
      tick(); tick(); tick();
      chk("hyst lvl9",    32'(wr_level), 9);
      chk("hyst afull9",  32'(almost_full), 1);
      rd_gray_ptr = g(8);
      tick(); tick(); tick();
      chk("hyst lvl8",    32'(wr_level), 8);
      chk("hyst afull8",  32'(almost_full), 0);
      wr_en = 1'b1;
      tick(); tick(); tick();
      chk("hyst lvl11",   32'(wr_level), 11);
      chk("hyst afull11", 32'(almost_full), 0);
      tick();
      chk("hyst lvl12",   32'(wr_level), 12);
      chk("hyst afull12", 32'(almost_full), 1);

      // Wrap-around: write pointer advances from 20 to 94 (wraps twice) with reads trailing
      for (int w = 21; w <= 94; w++) begin
         prev_gray   = wr_gray_ptr;
         rd_gray_ptr = g((w - 10) % 32);
         tick();
         chk("wrap gray",      32'(wr_gray_ptr), 32'(g(w % 32)));
         chk("wrap gray 1bit", 32'($countones(wr_gray_ptr ^ prev_gray)), 1);
         if (w >= 23) chk("wrap level", 32'(wr_level), 12);
      end
      wr_en = 1'b0;
      tick(); tick(); tick();
      chk("wrap final level", 32'(wr_level), 10);
      chk("wrap final full",  32'(full), 0);
      chk("wrap final addr",  32'(wr_addr), 14);
      chk("wrap final gray",  32'(wr_gray_ptr), 32'(g(30)));

      // Async reset mid-stream at level 7
      rd_gray_ptr = g(87 % 32);
      tick(); tick(); tick();
      chk("pre-reset level", 32'(wr_level), 7);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async reset");
      rd_gray_ptr = '0;
      afull_thr   = 5'd0;
      #2;
      rst_n = 1'b1;
      wr_en = 1'b1;
      #1;
      chk("post-reset we",   32'(wr_we), 1);
      chk("post-reset addr", 32'(wr_addr), 0);
      tick();
      chk("post-reset addr1",  32'(wr_addr), 1);
      chk("post-reset level1", 32'(wr_level), 1);
      chk("afull thr0",        32'(almost_full), 1);

      // Threshold above DEPTH never asserts
      wr_en     = 1'b0;
      afull_thr = 5'd17;
      tick();
      chk("afull thr17 clr", 32'(almost_full), 0);
      wr_en = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      wr_en = 1'b0;
      chk("thr17 level", 32'(wr_level), 16);
      chk("thr17 full",  32'(full), 1);
      chk("thr17 afull", 32'(almost_full), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain controller for the asynchronous FIFO, the parametrised successor to the write-side full generator. It owns the write pointer, exports it in Gray code to the read domain, synchronises the read-side Gray pointer, and produces registered full, programmable almost-full with hysteresis, fill level, and a sticky overflow flag. It sits between the write client and the dual-port RAM, alongside the matching read-domain controller.

## Interface
- ABITS, 10, RAM address width; DEPTH = 2^ABITS entries; pointers are ABITS+1 bits wide.
- SYNC_STAGES, 2, flops in the read-pointer synchroniser; legal range 2 to 4.
- AF_HYST, 0, almost-full hysteresis in entries; legal range 0 to DEPTH-1.

Ports:
- wrclk  in  1  write clock. Single clock; the block has no other clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  write request from the client.
- wr_addr  out  ABITS  RAM write address, equal to wr_bin[ABITS-1:0].
- wr_we  out  1  RAM write enable, equal to wr_en & ~full (combinational).
- wr_gray_ptr  out  ABITS+1  registered Gray-coded write pointer, sent to the read domain.
- rd_gray_ptr  in  ABITS+1  Gray-coded read pointer, asynchronous to wrclk.
- afull_thr  in  ABITS+1  almost-full threshold in entries; quasi-static.
- full  out  1  registered full flag.
- almost_full  out  1  registered almost-full flag.
- wr_level  out  ABITS+1  registered fill level, 0 to DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- ovf_clr  in  1  clears overflow.

## Operation
- A write is accepted when wr_en & ~full. On acceptance, wr_bin_nxt = wr_bin + 1 modulo 2^(ABITS+1); otherwise wr_bin_nxt = wr_bin.
- wr_gray_ptr is registered from bin2gray(wr_bin_nxt), so it always corresponds to wr_bin. Exactly one bit changes per write.
- rd_gray_ptr passes through SYNC_STAGES flops, giving rd_gray_s. rd_bin_s = gray2bin(rd_gray_s).
- lvl_nxt = (wr_bin_nxt - rd_bin_s) modulo 2^(ABITS+1). All registered status outputs are computed from lvl_nxt:
  - wr_level <= lvl_nxt.
  - full <= (lvl_nxt == DEPTH).
  - almost_full is set when lvl_nxt >= afull_thr.
  - almost_full is cleared when lvl_nxt < afull_thr - AF_HYST, where the subtraction saturates at 0.
  - Otherwise almost_full holds its value.
- Boundary cases for almost_full:
  - afull_thr = 0: almost_full is asserted from the first edge after reset.
  - afull_thr > DEPTH: almost_full never asserts.
- Status is pessimistic. Reads become visible only after synchronisation, so full and level may overstate occupancy but never understate it. The FIFO can never overflow.
- Overflow:
  - An attempted write (wr_en & full) sets overflow. The write is dropped and the pointer is unchanged.
  - ovf_clr clears overflow.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: the MSB of the ABITS+1-bit pointer distinguishes full from empty. Modular subtraction gives the correct level across every wrap.

## Timing
- Reset values: wr_bin 0, wr_addr 0, wr_gray_ptr 0, synchroniser flops 0, wr_level 0, full 0, almost_full 0, overflow 0.
- Reset is asynchronous. Asserting rst_n mid-operation returns every register to its reset value immediately, without waiting for a clock edge.
- Write latency: wr_en accepted at edge N → wr_addr, wr_gray_ptr, wr_level, full and almost_full all reflect that write after edge N. Full therefore blocks the very next cycle, and zero-cycle back-to-back writes are safe.
- Read latency: a change on rd_gray_ptr before edge M is reflected in wr_level, full and almost_full after edge M+SYNC_STAGES.
- When a write and a synchronised read occur in the same cycle, the level is unchanged.

## Structure
- Shared package fifo_pkg holds:
  - the bin2gray and gray2bin functions, parametrised by width;
  - the DEPTH calculation;
  - the legal-range constants for SYNC_STAGES.
  The read-domain controller uses the same package.
- Sub-module fifo_gray_sync: a SYNC_STAGES-deep flop chain of width ABITS+1 with async active-low reset. It is reused by the read-domain controller.

## Test plan
Bench configuration: ABITS=4 (DEPTH=16), SYNC_STAGES=2, rd_gray_ptr held at 0 unless stated.

- **Fill to full:** 16 consecutive writes → wr_level counts 1 to 16. full rises after the 16th edge. A 17th wr_en is dropped: wr_we=0, wr_addr stays 0, overflow=1.
- **Overflow clear:** ovf_clr pulsed alone → overflow=0. ovf_clr together with a write-while-full → overflow stays 1.
- **Wrap-around:** interleave writes with rd_gray_ptr updates so the pointer wraps twice. For rd = bin2gray(20) and wr_bin = 30, wr_level must be 10 and full 0. wr_gray_ptr must change exactly one bit per write.
- **Almost-full hysteresis:** afull_thr=12, AF_HYST=3 → asserts at level 12, stays asserted at levels 10 and 9, deasserts at level 8.
- **Read latency:** with the FIFO full, set rd_gray_ptr = bin2gray(1) just before edge M → full falls and wr_level=15 after edge M+2, not earlier.
- **Async reset mid-stream:** assert rst_n low between edges at level 7 → all outputs are 0 immediately. After release, the first write goes to wr_addr 0.
